// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit FIFO: transmit FSM encodings and default sizing.
package uart_pkg;

    localparam int DEFAULT_DEPTH  = 16;
    localparam int DEFAULT_ADDR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_WAIT = 2'b10
    } tx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with wrap-bit pointers; FULL/EMPTY/LEVEL are registered and
// reflect a push or pop on the edge that performs it. Storage is not reset.
module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            push_i,
    input  logic [7:0]      din_i,
    input  logic            pop_i,
    output logic [7:0]      dout_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [ADDR_W:0] level_o
);
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [7:0]      mem_q [DEPTH];
    logic [ADDR_W:0] wptr_q, wptr_d;
    logic [ADDR_W:0] rptr_q, rptr_d;
    logic [ADDR_W:0] level_q, level_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            push_ok, pop_ok;

    // A push while full is dropped even when a pop frees a slot on the same edge.
    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && !empty_q;

    always_comb begin
        wptr_d  = push_ok ? wptr_q + PTR_ONE : wptr_q;
        rptr_d  = pop_ok  ? rptr_q + PTR_ONE : rptr_q;
        level_d = wptr_d - rptr_d;
        empty_d = (wptr_d == rptr_d);
        full_d  = (wptr_d[ADDR_W] != rptr_d[ADDR_W]) &&
                  (wptr_d[ADDR_W-1:0] == rptr_d[ADDR_W-1:0]);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wptr_q[ADDR_W-1:0]] <= din_i;
        end
    end

    assign dout_o  = mem_q[rptr_q[ADDR_W-1:0]];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign level_o = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO in front of a UART serializer: pops one byte per frame and handshakes TX_DV/TX_DONE.
// Define UART_TX_FIFO_OVF_EN to add a sticky overflow flag (ovf_o) with clear input (ovf_clr_i).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic            ser_clk_i,
    input  logic            rst_n_i,
    input  logic            wr_en_i,
    input  logic [7:0]      wr_byte_i,
    output logic            full_o,
    output logic            empty_o,
    output logic [ADDR_W:0] level_o,
    output logic            tx_dv_o,
    output logic [7:0]      tx_byte_o,
    input  logic            tx_done_i,
    output logic            busy_o
`ifdef UART_TX_FIFO_OVF_EN
    ,
    output logic            ovf_o,
    input  logic            ovf_clr_i
`endif
);
    tx_state_e  state_q;
    logic       tx_dv_q;
    logic       busy_q;
    logic [7:0] tx_byte_q;
    logic [7:0] head;
    logic       pop;

    assign pop = (state_q == ST_IDLE) && !empty_o;

    byte_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk_i   (ser_clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (wr_en_i),
        .din_i   (wr_byte_i),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (full_o),
        .empty_o (empty_o),
        .level_o (level_o)
    );

    // state | meaning:  IDLE idle/pop head  |  SEND tx_dv pulse  |  WAIT frame on line, await tx_done
    always_ff @(posedge ser_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            tx_dv_q   <= 1'b0;
            busy_q    <= 1'b0;
            tx_byte_q <= 8'h00;
        end else begin
            tx_dv_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        tx_byte_q <= head;
                        tx_dv_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_done_i) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_dv_o   = tx_dv_q;
    assign tx_byte_o = tx_byte_q;
    assign busy_o    = busy_q;

`ifdef UART_TX_FIFO_OVF_EN
    logic ovf_q;

    // Set has priority over clear so an overflow in the clearing cycle is not lost.
    always_ff @(posedge ser_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ovf_q <= 1'b0;
        end else if (wr_en_i && full_o) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr_i) begin
            ovf_q <= 1'b0;
        end
    end

    assign ovf_o = ovf_q;
`endif

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of byte entries; SHALL be a power of two, 2..256.
REQ-002 Parameter ADDR_W, default 4, pointer width; SHALL equal log2(DEPTH).
REQ-003 SER_CLK  in  1  single system clock; all logic SHALL be on its rising edge.
REQ-004 RST_N  in  1  reset, asynchronous assert, active-low.
REQ-005 WR_EN  in  1  write strobe; one byte per cycle.
REQ-006 WR_BYTE  in  8  byte to enqueue.
REQ-007 FULL  out  1  high when LEVEL == DEPTH.
REQ-008 EMPTY  out  1  high when LEVEL == 0.
REQ-009 LEVEL  out  ADDR_W+1  current occupancy.
REQ-010 TX_DV  out  1  one-cycle send pulse to the serializer.
REQ-011 TX_BYTE  out  8  byte for the serializer; held stable from pop until TX_DONE.
REQ-012 TX_DONE  in  1  serializer end-of-frame pulse (its DONE output).
REQ-013 BUSY  out  1  high in every state except IDLE.

Function
REQ-014 A write with WR_EN=1 and FULL=0 SHALL store WR_BYTE at the write pointer and increment it modulo DEPTH.
REQ-015 A write with FULL=1 SHALL be dropped; storage and pointers unchanged, even if a pop occurs in the same cycle.
REQ-016 Pointers SHALL wrap from DEPTH-1 to 0; LEVEL SHALL be derived from ADDR_W+1-bit pointers, so full and empty are distinct.
REQ-017 A simultaneous accepted write and pop SHALL leave LEVEL unchanged.
REQ-018 FULL, EMPTY and LEVEL SHALL be registered and SHALL reflect a write or pop on the edge that performs it.
REQ-019 The FSM SHALL have the states IDLE, SEND and WAIT.
REQ-020 IDLE: if EMPTY=0, the FSM SHALL pop the head entry into TX_BYTE and go to SEND; otherwise it SHALL stay in IDLE.
REQ-021 SEND: the FSM SHALL drive TX_DV=1 for exactly one cycle, then go to WAIT.
REQ-022 WAIT: TX_DV SHALL be 0; on TX_DONE=1 the FSM SHALL go to IDLE; otherwise it SHALL stay in WAIT.
REQ-023 TX_DONE SHALL be ignored in IDLE and SEND.
REQ-024 Latency: a write into an empty FIFO idle at edge N SHALL give the pop at edge N+1 and TX_DV=1 in cycle N+2.
REQ-025 Back-to-back: after TX_DONE in cycle M with data pending, TX_DV SHALL be 1 in cycle M+2, never earlier.
REQ-026 TX_DV SHALL never be high for two consecutive cycles.

Reset
REQ-027 While RST_N=0: pointers and LEVEL SHALL be 0, EMPTY=1, FULL=0, TX_DV=0, TX_BYTE=8'h00, BUSY=0, state IDLE.
REQ-028 Reset mid-frame SHALL discard all queued bytes; the frame already handed to the serializer is not aborted, and its TX_DONE SHALL be ignored per REQ-023.
REQ-029 Storage array contents SHALL NOT be reset.

Configuration
REQ-030 Macro UART_TX_FIFO_OVF_EN SHALL control the overflow feature.
REQ-031 With UART_TX_FIFO_OVF_EN defined, the block SHALL add ports OVF (out, 1) and OVF_CLR (in, 1).
REQ-032 OVF SHALL set on any dropped write (REQ-015) and stay set until OVF_CLR=1 or reset; a set and a clear in the same cycle SHALL leave OVF=1.
REQ-033 Without UART_TX_FIFO_OVF_EN, OVF and OVF_CLR SHALL NOT exist and dropped writes SHALL be silent.

Structure
REQ-034 A shared package uart_pkg SHALL hold the FSM state encodings (IDLE=2'b00, SEND=2'b01, WAIT=2'b10) and the default DEPTH constant.
REQ-035 Storage and pointers SHALL live in one sub-module, byte_fifo (push/pop/full/empty/level); uart_tx_fifo SHALL hold the FSM and the serializer handshake.

Verification
REQ-036 Write 8'hA5 into an idle, empty block -> TX_DV pulse two cycles later with TX_BYTE=8'hA5; BUSY stays high until TX_DONE; EMPTY=1 after the pop.
REQ-037 Write 16 bytes 0x00..0x0F while the serializer is stalled -> FULL=1, LEVEL=16; a 17th write is dropped; the sequence then drains in order 0x00..0x0F.
REQ-038 Write and pop in the same cycle at LEVEL=5 -> LEVEL stays 5; pointers wrap correctly across 20 writes.
REQ-039 Assert RST_N=0 in WAIT with 3 bytes queued -> all outputs return to reset values; a later TX_DONE causes no TX_DV.
REQ-040 With UART_TX_FIFO_OVF_EN: write when full -> OVF=1; OVF_CLR=1 -> OVF=0 next cycle; simultaneous overflow and OVF_CLR -> OVF=1.
REQ-041 Connect to the serializer at 9600 baud, queue "Hi\n" -> the line carries 0x48, 0x69, 0x0A as 8N1 frames in order, with no extra TX_DV pulses.
